inst_fetch: RTL and testbench

Instruction fetch stage of the single-clock MIPS core. It sits directly upstream of the instruction decoder and register-read logic that drive the `dbg_inst`, `dbg_a`, `dbg_b` and `dbg_op` observation points. The stage owns the program counter and issues word reads to a synchronous instruction ROM. Fetched words and their PCs go into a 2-entry buffer that feeds decode over a valid/ready handshake, and a branch/jump redirect flushes the stage.

---
 rtl/inst_fetch.sv | 120 ++++++++++++
 tb/tb_inst_fetch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues reads to a synchronous ROM and
// queues {pc, inst} pairs in a 2-entry FIFO that feeds decode over valid/ready.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 6
) (
    input  logic               CLK,
    input  logic               RST,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [31:0]        inst,
    output logic [31:0]        inst_pc,
    output logic [31:0]        dbg_pc
);

    logic [31:0] pc_req_q, pc_req_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        inflight_q, inflight_d;
    logic        kill_q, kill_d;
    logic [1:0]  occ_q, occ_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] fifo_pc_q [2];
    logic [31:0] fifo_pc_d [2];
    logic [31:0] fifo_inst_q [2];
    logic [31:0] fifo_inst_d [2];

    logic        push;
    logic        pop;
    logic        issue;
    logic [2:0]  pending;
    logic        unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign inst_valid = (occ_q != 2'd0);
    assign inst       = inst_valid ? fifo_inst_q[rd_ptr_q] : 32'h0;
    assign inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q] : 32'h0;
    assign dbg_pc     = pc_req_q;
    assign imem_addr  = pc_req_q[IMEM_AW+1:2];
    assign imem_en    = issue;

    // Issue only when the buffer can absorb every outstanding response.
    always_comb begin
        pop     = inst_valid & inst_ready;
        push    = inflight_q & ~kill_q;
        pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue   = ~RST & ~redirect & (pending < 3'd2);
    end

    always_comb begin
        pc_req_d    = pc_req_q;
        req_pc_d    = req_pc_q;
        inflight_d  = inflight_q;
        kill_d      = kill_q;
        occ_d       = occ_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_inst_d = fifo_inst_q;

        if (redirect) begin
            // Redirect wins: flush the buffer, void any pop, drop the read in flight.
            occ_d      = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            kill_d     = inflight_q;
            inflight_d = 1'b0;
            pc_req_d   = {redirect_pc[31:2], 2'b00};
        end else begin
            kill_d     = 1'b0;
            inflight_d = issue;
            if (issue) begin
                req_pc_d = pc_req_q;
                pc_req_d = pc_req_q + 32'd4;
            end
            if (push) begin
                fifo_pc_d[wr_ptr_q]   = req_pc_q;
                fifo_inst_d[wr_ptr_q] = imem_data;
                wr_ptr_d              = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            occ_d = occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_req_q   <= RESET_PC;
            req_pc_q   <= 32'h0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            occ_q      <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else begin
            pc_req_q   <= pc_req_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            occ_q      <= occ_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Buffer storage needs no reset; outputs are masked while the buffer is empty.
    always_ff @(posedge CLK) begin
        fifo_pc_q   <= fifo_pc_d;
        fifo_inst_q <= fifo_inst_d;
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a synchronous ROM model holding 32'h1000_0000+i
// and one task per scenario with hand-computed expected PCs and words.
module tb_inst_fetch;

    localparam int AW = 6;

    logic          CLK;
    logic          RST;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst;
    logic [31:0]   inst_pc;
    logic [31:0]   dbg_pc;

    int checks = 0;
    int errors = 0;

    inst_fetch #(.RESET_PC(32'h0000_0000), .IMEM_AW(AW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .dbg_pc     (dbg_pc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous ROM: word i holds 32'h1000_0000 + i.
    always @(posedge CLK) begin
        if (imem_en) imem_data <= 32'h1000_0000 + {26'b0, imem_addr};
    end

    // A push into a full buffer without a pop would overflow it.
    always @(negedge CLK) begin
        if (!RST && !redirect && dut.push && dut.occ_q == 2'd2 && !dut.pop) begin
            errors++;
            $display("[TB] FAIL fifo_overflow got push into occ=%0d exp no push", dut.occ_q);
        end
    end

    task step;
        @(posedge CLK);
        #1;
    endtask

    // Holds reset for two cycles; returns inside cycle 0 with RST low.
    task do_reset;
        RST = 1'b1;
        redirect = 1'b0;
        inst_ready = 1'b1;
        step;
        step;
        RST = 1'b0;
    endtask

    task test_reset;
        RST = 1'b1;
        redirect = 1'b0;
        inst_ready = 1'b1;
        step; step; step;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %b exp 0", inst_valid); end
        checks++; if (inst !== 32'h0) begin errors++; $display("[TB] FAIL rst_inst got %h exp 0", inst); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_inst_pc got %h exp 0", inst_pc); end
        checks++; if (imem_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_imem_en got %b exp 0", imem_en); end
        checks++; if (imem_addr !== 6'd0) begin errors++; $display("[TB] FAIL rst_imem_addr got %0d exp 0", imem_addr); end
        checks++; if (dbg_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_dbg_pc got %h exp 0", dbg_pc); end
    endtask

    task test_sequential;
        do_reset;
        #1;
        checks++; if (imem_en !== 1'b1) begin errors++; $display("[TB] FAIL seq_c0_en got %b exp 1", imem_en); end
        checks++; if (imem_addr !== 6'd0) begin errors++; $display("[TB] FAIL seq_c0_addr got %0d exp 0", imem_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_c0_valid got %b exp 0", inst_valid); end
        step; #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_c1_valid got %b exp 0", inst_valid); end
        for (int k = 0; k < 8; k++) begin
            step; #1;
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid k=%0d got %b exp 1", k, inst_valid); end
            checks++; if (inst_pc !== 32'(4 * k)) begin errors++; $display("[TB] FAIL seq_pc k=%0d got %h exp %h", k, inst_pc, 32'(4 * k)); end
            checks++; if (inst !== 32'h1000_0000 + 32'(k)) begin errors++; $display("[TB] FAIL seq_inst k=%0d got %h exp %h", k, inst, 32'h1000_0000 + 32'(k)); end
        end
    endtask

    task test_backpressure;
        do_reset;
        step; step; step; step;
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid i=%0d got %b exp 1", i, inst_valid); end
            checks++; if (inst_pc !== 32'h8) begin errors++; $display("[TB] FAIL bp_pc i=%0d got %h exp 8", i, inst_pc); end
            checks++; if (inst !== 32'h1000_0002) begin errors++; $display("[TB] FAIL bp_inst i=%0d got %h exp 10000002", i, inst); end
            checks++; if (imem_en !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall_en i=%0d got %b exp 0", i, imem_en); end
            step;
        end
        inst_ready = 1'b1;
        #1;
        checks++; if (imem_en !== 1'b1) begin errors++; $display("[TB] FAIL bp_resume_en got %b exp 1", imem_en); end
        checks++; if (imem_addr !== 6'd4) begin errors++; $display("[TB] FAIL bp_resume_addr got %0d exp 4", imem_addr); end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin step; #1; end
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_seq_valid k=%0d got %b exp 1", k, inst_valid); end
            checks++; if (inst_pc !== 32'(8 + 4 * k)) begin errors++; $display("[TB] FAIL bp_seq_pc k=%0d got %h exp %h", k, inst_pc, 32'(8 + 4 * k)); end
            checks++; if (inst !== 32'h1000_0002 + 32'(k)) begin errors++; $display("[TB] FAIL bp_seq_inst k=%0d got %h exp %h", k, inst, 32'h1000_0002 + 32'(k)); end
        end
    endtask

    task test_redirect_inflight;
        do_reset;
        step; step; step;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0043;
        #1;
        checks++; if (inst_pc !== 32'h4) begin errors++; $display("[TB] FAIL rdi_pre_pc got %h exp 4", inst_pc); end
        checks++; if (imem_en !== 1'b0) begin errors++; $display("[TB] FAIL rdi_R_en got %b exp 0", imem_en); end
        step;
        redirect = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rdi_R1_valid got %b exp 0", inst_valid); end
        checks++; if (imem_en !== 1'b1) begin errors++; $display("[TB] FAIL rdi_R1_en got %b exp 1", imem_en); end
        checks++; if (imem_addr !== 6'd16) begin errors++; $display("[TB] FAIL rdi_R1_addr got %0d exp 16", imem_addr); end
        checks++; if (dbg_pc !== 32'h40) begin errors++; $display("[TB] FAIL rdi_R1_dbg_pc got %h exp 40", dbg_pc); end
        step; #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rdi_R2_valid got %b exp 0", inst_valid); end
        for (int k = 0; k < 2; k++) begin
            step; #1;
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL rdi_valid k=%0d got %b exp 1", k, inst_valid); end
            checks++; if (inst_pc !== 32'(64 + 4 * k)) begin errors++; $display("[TB] FAIL rdi_pc k=%0d got %h exp %h", k, inst_pc, 32'(64 + 4 * k)); end
            checks++; if (inst !== 32'h1000_0010 + 32'(k)) begin errors++; $display("[TB] FAIL rdi_inst k=%0d got %h exp %h", k, inst, 32'h1000_0010 + 32'(k)); end
        end
    endtask

    task test_redirect_stall;
        do_reset;
        step; step; step; step;
        inst_ready = 1'b0;
        step; step;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0020;
        #1;
        checks++; if (inst_pc !== 32'h8) begin errors++; $display("[TB] FAIL rds_pre_pc got %h exp 8", inst_pc); end
        checks++; if (imem_en !== 1'b0) begin errors++; $display("[TB] FAIL rds_R_en got %b exp 0", imem_en); end
        step;
        redirect = 1'b0;
        inst_ready = 1'b1;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rds_R1_valid got %b exp 0", inst_valid); end
        step; #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rds_R2_valid got %b exp 0", inst_valid); end
        step; #1;
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL rds_R3_valid got %b exp 1", inst_valid); end
        checks++; if (inst_pc !== 32'h20) begin errors++; $display("[TB] FAIL rds_R3_pc got %h exp 20", inst_pc); end
        checks++; if (inst !== 32'h1000_0008) begin errors++; $display("[TB] FAIL rds_R3_inst got %h exp 10000008", inst); end
        step; #1;
        checks++; if (inst_pc !== 32'h24) begin errors++; $display("[TB] FAIL rds_R4_pc got %h exp 24", inst_pc); end
    endtask

    task test_wrap;
        logic [31:0] exp_pc [3];
        logic [AW-1:0] exp_addr [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
        exp_addr[0] = 6'd62; exp_addr[1] = 6'd63; exp_addr[2] = 6'd0;
        do_reset;
        step; step; step;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step;
        redirect = 1'b0;
        #1;
        checks++; if (dbg_pc !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL wrap_dbg_pc got %h exp fffffff8", dbg_pc); end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin step; #1; end
            checks++; if (imem_addr !== exp_addr[k]) begin errors++; $display("[TB] FAIL wrap_addr k=%0d got %0d exp %0d", k, imem_addr, exp_addr[k]); end
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin step; end
            #1;
            checks++; if (inst_pc !== exp_pc[k]) begin errors++; $display("[TB] FAIL wrap_pc k=%0d got %h exp %h", k, inst_pc, exp_pc[k]); end
            checks++; if (inst !== 32'h1000_0000 + {26'b0, exp_addr[k]}) begin errors++; $display("[TB] FAIL wrap_inst k=%0d got %h exp %h", k, inst, 32'h1000_0000 + {26'b0, exp_addr[k]}); end
        end
    endtask

    task test_reset_mid;
        do_reset;
        step; step; step; step;
        RST = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0030;
        #1;
        checks++; if (imem_en !== 1'b0) begin errors++; $display("[TB] FAIL rmid_en got %b exp 0", imem_en); end
        step;
        RST = 1'b0;
        redirect = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_valid got %b exp 0", inst_valid); end
        checks++; if (dbg_pc !== 32'h0) begin errors++; $display("[TB] FAIL rmid_dbg_pc got %h exp 0", dbg_pc); end
        checks++; if (imem_addr !== 6'd0) begin errors++; $display("[TB] FAIL rmid_addr got %0d exp 0", imem_addr); end
        step; #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_c1_valid got %b exp 0", inst_valid); end
        for (int k = 0; k < 3; k++) begin
            step; #1;
            checks++; if (inst_pc !== 32'(4 * k)) begin errors++; $display("[TB] FAIL rmid_pc k=%0d got %h exp %h", k, inst_pc, 32'(4 * k)); end
            checks++; if (inst !== 32'h1000_0000 + 32'(k)) begin errors++; $display("[TB] FAIL rmid_inst k=%0d got %h exp %h", k, inst, 32'h1000_0000 + 32'(k)); end
        end
    endtask

    initial begin
        RST = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        inst_ready = 1'b0;
        test_reset;
        test_sequential;
        test_backpressure;
        test_redirect_inflight;
        test_redirect_stall;
        test_wrap;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
